// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// State encoding and iteration count used by mul16_seq.
package mul_pkg;

    localparam int unsigned MUL_ITER = 16;

    // 2'd3 is unused; the FSM treats it as illegal and falls back to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul16_seq_rca.sv
// Ripple-carry adder: a chain of full adders with carry-out and signed overflow flag.
module mul16_seq_rca #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry[0] = cin_i;
        sum_o    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carry[WIDTH];
    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    assign ovf_o  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one add/shift step per clock,
// with a start/busy/done handshake and a held 32-bit product plus 16-bit overflow flag.
module mul16_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Product,
    output logic               of
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               of_q, of_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               rca_ovf_unused;
    logic [2*WIDTH-1:0] shifted;
    logic               accept;
    logic               last_step;

    assign add_b = q_q[0] ? m_q : '0;

    mul16_seq_rca #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a_i    (p_hi_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (rca_ovf_unused)
    );

    // Carry-out lands in the new accumulator MSB, so no product bit is ever lost.
    assign shifted   = {add_cout, add_sum, q_q[WIDTH-1:1]};
    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_step = (count_q == CNT_W'(MUL_ITER - 1));

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_hi_d    = p_hi_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;
        of_d      = of_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    m_d     = A;
                    q_d     = B;
                    p_hi_d  = '0;
                    count_d = '0;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                p_hi_d  = shifted[2*WIDTH-1:WIDTH];
                q_d     = shifted[WIDTH-1:0];
                count_d = count_q + 1'b1;
                if (last_step) begin
                    state_d   = S_DONE;
                    product_d = shifted;
                    of_d      = (shifted[2*WIDTH-1:WIDTH] != '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            p_hi_q    <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            of_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_hi_q    <= p_hi_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
            of_q      <= of_d;
        end
    end

    assign busy    = (state_q == S_CALC);
    assign done    = (state_q == S_DONE);
    assign Product = product_q;
    assign of      = of_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Randomized self-checking bench for mul16_seq against an operation-level timing/arithmetic model.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done, of_flag;
    logic [31:0] product;

    int vectors     = 0;
    int miscompares = 0;
    int ops_done    = 0;

    mul16_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (a),
        .B       (b),
        .busy    (busy),
        .done    (done),
        .Product (product),
        .of      (of_flag)
    );

    always #5 clk = ~clk;

    // Model: age counts cycles since acceptance (0 = no op, 1..16 busy, 17 result cycle).
    int          age;
    logic [15:0] op_a, op_b;
    logic [31:0] exp_prod;
    logic        exp_of;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age      <= 0;
            exp_prod <= '0;
            exp_of   <= 1'b0;
        end else if ((age == 0 || age == 17) && start) begin
            age  <= 1;
            op_a <= a;
            op_b <= b;
        end else if (age == 16) begin
            age      <= 17;
            exp_prod <= 32'(op_a) * 32'(op_b);
            exp_of   <= (32'(op_a) * 32'(op_b)) > 32'h0000_FFFF;
        end else if (age == 17) begin
            age <= 0;
        end else if (age != 0) begin
            age <= age + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", {31'b0, busy}, {31'b0, (age >= 1 && age <= 16)});
        check("done", {31'b0, done}, {31'b0, (age == 17)});
        check("product", product, exp_prod);
        check("of", {31'b0, of_flag}, {31'b0, exp_of});
        check("busy_and_done", {31'b0, busy & done}, 32'd0);
        if (age == 17) ops_done++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] x, input logic [15:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        cyc();
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    // Checks 16 busy cycles then the done cycle; optionally pulses a restart attempt mid-run.
    task automatic expect_run(input logic [31:0] ep, input logic eo, input int restart_at);
        for (int i = 1; i <= 16; i++) begin
            check("lat_busy", {31'b0, busy}, 32'd1);
            check("lat_done", {31'b0, done}, 32'd0);
            if (i == restart_at) begin
                start = 1'b1;
                a     = 16'd2;
                b     = 16'd2;
            end
            cyc();
            start = 1'b0;
        end
        check("lit_done", {31'b0, done}, 32'd1);
        check("lit_product", product, ep);
        check("lit_of", {31'b0, of_flag}, {31'b0, eo});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) cyc();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_of", {31'b0, of_flag}, 32'd0);
        rst = 1'b0;
        cyc();

        accept(16'd3, 16'd5);           expect_run(32'h0000_000F, 1'b0, 0); cyc();
        accept(16'hFFFF, 16'hFFFF);     expect_run(32'hFFFE_0001, 1'b1, 0); cyc();
        accept(16'h1234, 16'h0000);     expect_run(32'h0000_0000, 1'b0, 0); cyc();
        accept(16'h0000, 16'hABCD);     expect_run(32'h0000_0000, 1'b0, 0); cyc();
        accept(16'h0100, 16'h0100);     expect_run(32'h0001_0000, 1'b1, 0); cyc();

        // Restart attempt mid-run is ignored; restart in the done cycle is taken.
        accept(16'd7, 16'd9);           expect_run(32'd63, 1'b0, 5);
        accept(16'd2, 16'd2);           expect_run(32'd4, 1'b0, 0); cyc();

        // Asynchronous reset in the middle of a calculation.
        accept(16'd100, 16'd200);
        repeat (7) cyc();
        #1 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_product", product, 32'd0);
        check("arst_of", {31'b0, of_flag}, 32'd0);
        #1 rst = 1'b0;
        repeat (2) cyc();
        accept(16'd10, 16'd10);         expect_run(32'd100, 1'b0, 0);

        // Random operations with idle gaps, back-to-back starts and ignored mid-run starts.
        for (int n = 0; n < 1100; n++) begin
            int gap;
            int waited;
            gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            repeat (gap) cyc();
            case ($urandom_range(0, 3))
                0:       accept(16'hFFFF, 16'($urandom));
                1:       accept(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
                default: accept(16'($urandom), 16'($urandom));
            endcase
            waited = 0;
            while (!done && waited < 40) begin
                start = ($urandom_range(0, 7) == 0);
                a     = 16'($urandom);
                b     = 16'($urandom);
                cyc();
                waited++;
            end
            start = 1'b0;
            check("done_timeout", {31'b0, done}, 32'd1);
        end
        cyc();
        check("ops_completed_min", {31'b0, ops_done >= 1100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before t=2000000");
        $fatal(1);
    end

endmodule
